// File: rtl/conway_pkg.sv
// Shared definitions for the Conway board frame transmitter: header byte,
// transmitter state encoding and the default board height.
package conway_pkg;

  localparam logic [7:0] HDR_BYTE     = 8'hA5;
  localparam int         ROWS_DEFAULT = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_GEN,
    ST_ROW,
    ST_CSUM
  } tx_state_t;

endpackage

// File: rtl/conway_frame_tx.sv
// Conway board frame transmitter.
// Sends one frame per accepted frame_start over a valid/ready byte stream:
//   0xA5, generation, row 0 .. row ROWS-1 [, checksum]
// Board and generation are captured when the frame is accepted, so the
// producer may keep updating them while the frame is on the wire.
// Optional feature macro: CONWAY_TX_CSUM_EN appends an XOR checksum byte
// covering the generation byte and all row bytes (the header is excluded).
module conway_frame_tx
  import conway_pkg::*;
#(
  parameter int ROWS = ROWS_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [8*ROWS-1:0] board,
  input  logic [7:0]        generation,
  input  logic              frame_start,
  output logic              busy,
  output logic [7:0]        out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              frame_done
);

  // Row index carries one spare bit so it can never wrap back onto row 0.
  localparam int              IDX_W    = $clog2(ROWS) + 1;
  localparam int              SEL_W    = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [IDX_W-1:0] LAST_ROW = IDX_W'(ROWS - 1);

  tx_state_t        state;
  tx_state_t        state_nxt;
  logic [IDX_W-1:0] row_idx;
  logic [SEL_W-1:0] row_sel;
  logic [7:0]       gen_snap;
  logic [7:0]       rows_snap [ROWS];
  logic             accept;
  logic             xfer;
  logic             last_row;
`ifdef CONWAY_TX_CSUM_EN
  logic [7:0]       csum;
`endif

  // A start request only counts in IDLE; reset wins over a same-cycle start.
  assign accept   = (state == ST_IDLE) && frame_start && !rst;
  assign xfer     = out_valid && out_ready;
  assign last_row = (row_idx == LAST_ROW);
  assign row_sel  = SEL_W'(row_idx);

  // Control state: FSM register and row index, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      row_idx <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        row_idx <= '0;
      end else if ((state == ST_ROW) && xfer && !last_row) begin
        row_idx <= row_idx + IDX_W'(1);
      end
    end
  end

  // Frame payload snapshot, captured once per accepted frame.
  always_ff @(posedge clk) begin
    if (accept) begin
      gen_snap <= generation;
      for (int r = 0; r < ROWS; r++) begin
        rows_snap[r] <= board[8*r +: 8];
      end
    end
  end

`ifdef CONWAY_TX_CSUM_EN
  // Running XOR checksum: seeded by the generation byte, folded with each row.
  always_ff @(posedge clk) begin
    if (rst) begin
      csum <= '0;
    end else if (accept) begin
      csum <= '0;
    end else if (xfer) begin
      if (state == ST_GEN) begin
        csum <= gen_snap;
      end else if (state == ST_ROW) begin
        csum <= csum ^ rows_snap[row_sel];
      end
    end
  end
`endif

  // Next-state and output decode; outputs are forced idle while in reset.
  always_comb begin
    state_nxt  = state;
    out_valid  = 1'b0;
    busy       = 1'b0;
    out_data   = '0;
    frame_done = 1'b0;

    case (state)
      ST_IDLE: begin
        if (frame_start) begin
          state_nxt = ST_HDR;
        end
      end

      ST_HDR: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        out_data  = HDR_BYTE;
        if (out_ready) begin
          state_nxt = ST_GEN;
        end
      end

      ST_GEN: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        out_data  = gen_snap;
        if (out_ready) begin
          state_nxt = ST_ROW;
        end
      end

      ST_ROW: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        out_data  = rows_snap[row_sel];
        if (out_ready && last_row) begin
`ifdef CONWAY_TX_CSUM_EN
          state_nxt = ST_CSUM;
`else
          state_nxt  = ST_IDLE;
          frame_done = 1'b1;
`endif
        end
      end

      ST_CSUM: begin
`ifdef CONWAY_TX_CSUM_EN
        out_valid = 1'b1;
        busy      = 1'b1;
        out_data  = csum;
        if (out_ready) begin
          state_nxt  = ST_IDLE;
          frame_done = 1'b1;
        end
`else
        state_nxt = ST_IDLE;
`endif
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase

    if (rst) begin
      out_valid  = 1'b0;
      busy       = 1'b0;
      out_data   = '0;
      frame_done = 1'b0;
    end
  end

endmodule
